// File: rtl/aes_stream_ctrl.sv
// Serial-lane front end for a 128-bit AES core: assembles key/plaintext beats, runs the core,
// serialises the ciphertext. Optional block counter port blk_cnt under AES_STREAM_BLKCNT_EN.
module aes_stream_ctrl #(
    parameter int unsigned LANE_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LANE_W-1:0] DIN,
    input  logic              EN,
    input  logic [LANE_W-1:0] K_IN,
    input  logic              K_EN,
    output logic [LANE_W-1:0] DOUT,
    output logic              OUT_VAL,
    output logic              BUSY,
    output logic [127:0]      core_key,
    output logic              core_key_vld,
    output logic [127:0]      core_din,
    output logic              core_start,
    input  logic              core_done,
    input  logic [127:0]      core_dout
`ifdef AES_STREAM_BLKCNT_EN
    ,
    output logic [15:0]       blk_cnt
`endif
);

    localparam int unsigned N  = 128 / LANE_W;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] Last = CW'(N - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StHold, StStart, StWait, StShift
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] kcnt_q, kcnt_d;
    logic [127:0]  din_sr_q, din_sr_d;
    logic [127:0]  out_sr_q, out_sr_d;
    logic [127:0]  key_sr_q, key_sr_d;
    logic [127:0]  core_key_q, core_key_d;
    logic [127:0]  pend_key_q, pend_key_d;
    logic          key_vld_q, key_vld_d;
    logic          key_ready_q, key_ready_d;
    logic          pend_q, pend_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;

    logic [127:0]  key_asm;
    logic          key_done;
    logic          key_open;
    logic          to_idle;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kcnt_d      = kcnt_q;
        din_sr_d    = din_sr_q;
        out_sr_d    = out_sr_q;
        key_sr_d    = key_sr_q;
        core_key_d  = core_key_q;
        pend_key_d  = pend_key_q;
        key_vld_d   = 1'b0;
        key_ready_d = key_ready_q;
        pend_d      = pend_q;
        blk_cnt_d   = blk_cnt_q;

        key_asm  = {key_sr_q[127-LANE_W:0], K_IN};
        key_done = K_EN && (kcnt_q == Last);
        key_open = (state_q == StIdle) || (state_q == StLoad) || (state_q == StHold);
        to_idle  = (state_q == StShift) && (cnt_q == Last);

        if (K_EN) begin
            key_sr_d = key_asm;
            kcnt_d   = key_done ? '0 : kcnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StLoad: begin
                if (EN) begin
                    din_sr_d = {din_sr_q[127-LANE_W:0], DIN};
                    if (cnt_q == Last) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StHold: begin
                if (key_ready_q && !pend_q) state_d = StStart;
            end
            StStart: state_d = StWait;
            StWait: begin
                if (core_done) begin
                    out_sr_d = core_dout;
                    state_d  = StShift;
                end
            end
            StShift: begin
                out_sr_d = {out_sr_q[127-LANE_W:0], {LANE_W{1'b0}}};
                if (to_idle) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    blk_cnt_d = blk_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A key finishing while the core is busy is parked until the SHIFT->IDLE edge.
        if (key_done && (key_open || to_idle)) begin
            core_key_d  = key_asm;
            key_vld_d   = 1'b1;
            key_ready_d = 1'b1;
            pend_d      = 1'b0;
        end else if (key_done) begin
            pend_d     = 1'b1;
            pend_key_d = key_asm;
        end else if (to_idle && pend_q) begin
            core_key_d  = pend_key_q;
            key_vld_d   = 1'b1;
            key_ready_d = 1'b1;
            pend_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            kcnt_q      <= '0;
            din_sr_q    <= '0;
            out_sr_q    <= '0;
            key_sr_q    <= '0;
            core_key_q  <= '0;
            pend_key_q  <= '0;
            key_vld_q   <= 1'b0;
            key_ready_q <= 1'b0;
            pend_q      <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kcnt_q      <= kcnt_d;
            din_sr_q    <= din_sr_d;
            out_sr_q    <= out_sr_d;
            key_sr_q    <= key_sr_d;
            core_key_q  <= core_key_d;
            pend_key_q  <= pend_key_d;
            key_vld_q   <= key_vld_d;
            key_ready_q <= key_ready_d;
            pend_q      <= pend_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_comb begin
        OUT_VAL      = (state_q == StShift);
        DOUT         = OUT_VAL ? out_sr_q[127 -: LANE_W] : '0;
        BUSY         = !((state_q == StIdle) || (state_q == StLoad));
        core_start   = (state_q == StStart);
        core_din     = din_sr_q;
        core_key     = core_key_q;
        core_key_vld = key_vld_q;
    end

`ifdef AES_STREAM_BLKCNT_EN
    assign blk_cnt = blk_cnt_q;
`else
    logic unused_blk_cnt;
    assign unused_blk_cnt = ^blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Scoreboard bench for aes_stream_ctrl (LANE_W=8): random blocks/keys, behavioural core model,
// output monitor popping expected ciphertexts.
module tb_aes_stream_ctrl;
    localparam int LW = 8;
    localparam int NB = 128 / LW;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [LW-1:0] DIN = '0, K_IN = '0, DOUT;
    logic          EN = 1'b0, K_EN = 1'b0, OUT_VAL, BUSY;
    logic [127:0]  core_key, core_din;
    logic          core_key_vld, core_start;
    logic          core_done = 1'b0;
    logic [127:0]  core_dout = '0;
`ifdef AES_STREAM_BLKCNT_EN
    logic [15:0]   blk_cnt;
`endif

    aes_stream_ctrl #(.LANE_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .DIN(DIN), .EN(EN), .K_IN(K_IN), .K_EN(K_EN),
        .DOUT(DOUT), .OUT_VAL(OUT_VAL), .BUSY(BUSY), .core_key(core_key),
        .core_key_vld(core_key_vld), .core_din(core_din), .core_start(core_start),
        .core_done(core_done), .core_dout(core_dout)
`ifdef AES_STREAM_BLKCNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    logic [127:0] exp_q[$], blk_q[$], key_q[$];
    logic [127:0] model_key = '0;
    int core_dly = 2, starts = 0, spur_req = 0, spur_ack = 0;
    int start_cyc = -1, vld_cyc = -1, last_ov_cyc = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        tests++;
        fails++;
        $display("FAIL %s", msg);
    endtask

    // Stand-in for the cipher: FIPS-197 known answer for its vector, a keyed mix otherwise.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_K && d == FIPS_P) return FIPS_C;
        return d ^ {k[90:0], k[127:91]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor
    initial begin
        int beat = 0;
        logic [127:0] cur = '0;
        forever begin
            @(negedge clk);
            if (OUT_VAL) begin
                if (beat == 0) begin
                    if (exp_q.size() == 0) fail_now("dout: output with no expected block");
                    else cur = exp_q.pop_front();
                end
                chk($sformatf("dout beat %0d", beat), DOUT, cur[127-LW*beat -: LW]);
                beat = (beat + 1) % NB;
                last_ov_cyc = cyc;
            end else begin
                chk("dout zero when idle", DOUT, 0);
                if (beat != 0) fail_now($sformatf("out_val run: got %0d beats expected %0d", beat, NB));
                beat = 0;
            end
        end
    end

    // Key-load monitor
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (core_key_vld) begin
                vld_cyc = cyc;
                if (prev) fail_now("core_key_vld: got 2-cycle pulse expected 1");
                if (key_q.size() == 0) fail_now("core_key_vld: pulse with no expected key");
                else chk("core_key", core_key, key_q.pop_front());
            end
            prev = core_key_vld;
        end
    end

    // Core model; also injects core_done pulses on request while the DUT is idle
    initial begin
        logic [127:0] k, d;
        forever begin
            @(negedge clk);
            if (core_start && reset_n) begin
                starts++;
                start_cyc = cyc;
                k = core_key;
                d = core_din;
                if (blk_q.size() == 0) fail_now("core_start: got pulse expected none");
                else chk("core_din", d, blk_q.pop_front());
                repeat (core_dly) @(posedge clk);
                #1;
                core_done = 1'b1;
                core_dout = cipher(k, d);
                @(posedge clk);
                #1;
                core_done = 1'b0;
                core_dout = rnd128();
            end else if (spur_ack != spur_req) begin
                @(posedge clk);
                #1;
                core_done = 1'b1;
                core_dout = rnd128();
                @(posedge clk);
                #1;
                core_done = 1'b0;
                spur_ack++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [127:0] b, input int cnt, input bit gaps, output int t);
        t = cyc;
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    EN = 1'b0;
                    DIN = LW'($urandom);
                    tick();
                end
            end
            EN = 1'b1;
            DIN = b[127-LW*i -: LW];
            t = cyc;
            tick();
        end
        EN = 1'b0;
        DIN = '0;
    endtask

    task automatic send_block(input logic [127:0] b, input bit push_exp, input bit gaps,
                              output int t);
        send_beats(b, NB, gaps, t);
        blk_q.push_back(b);
        if (push_exp) exp_q.push_back(cipher(model_key, b));
    endtask

    task automatic send_key(input logic [127:0] k, output int t);
        t = cyc;
        for (int i = 0; i < NB; i++) begin
            K_EN = 1'b1;
            K_IN = k[127-LW*i -: LW];
            t = cyc;
            tick();
        end
        K_EN = 1'b0;
        K_IN = '0;
        key_q.push_back(k);
        model_key = k;
    endtask

    // Hammer EN with 0xff until the output burst has finished and the DUT is back in idle
    task automatic drain();
        int n = 0;
        bit seen = 1'b0;
        while (!(seen && !OUT_VAL)) begin
            if (OUT_VAL) seen = 1'b1;
            if (n++ > 3000) begin
                fail_now("drain: output burst never completed");
                break;
            end
            EN = 1'b1;
            DIN = '1;
            tick();
        end
        EN = 1'b0;
        DIN = '0;
    endtask

    task automatic wait_start(input int n0);
        int k = 0;
        while (starts == n0 && k < 500) begin
            tick();
            k++;
        end
        if (starts == n0) fail_now("core_start: got none expected a pulse");
    endtask

    initial begin
        int t, tk, n0;
        logic [127:0] b, old, nk;

        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("reset OUT_VAL", OUT_VAL, 0);
        chk("reset BUSY", BUSY, 0);
        chk("reset core_key", core_key, 0);
        chk("reset core_din", core_din, 0);
        chk("reset core_start", core_start, 0);
        chk("reset core_key_vld", core_key_vld, 0);
`ifdef AES_STREAM_BLKCNT_EN
        chk("reset blk_cnt", blk_cnt, 0);
`endif
        reset_n = 1'b1;
        tick();

        // Plaintext before any key: must wait in HOLD
        send_block(FIPS_P, 1'b0, 1'b0, t);
        for (int i = 0; i < 20; i++) begin
            EN = 1'b1;
            DIN = '1;
            if (core_start) fail_now("no-key hold: got core_start=1 expected 0");
            if (i == 10) chk("no-key hold BUSY", BUSY, 1);
            tick();
        end
        EN = 1'b0;
        send_key(FIPS_K, tk);
        exp_q.push_back(cipher(model_key, FIPS_P));
        drain();
        chk("start 2 cycles after last key beat", start_cyc, tk + 2);

        // Random blocks, occasional key reloads and stray core_done pulses in idle
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) send_key(rnd128(), tk);
            if ($urandom_range(0, 1) == 0) begin
                spur_req++;
                for (int w = 0; w < 20 && spur_ack != spur_req; w++) tick();
                tick();
                chk("stray core_done ignored, BUSY", BUSY, 0);
            end
            core_dly = $urandom_range(1, 8);
            send_block(rnd128(), 1'b1, 1'b1, t);
            drain();
            chk("start 2 cycles after last data beat", start_cyc, t + 2);
        end

        // Key completing while the core is busy is deferred to the return to idle
        old = model_key;
        nk = rnd128();
        core_dly = 60;
        n0 = starts;
        send_block(rnd128(), 1'b1, 1'b0, t);
        wait_start(n0);
        send_key(nk, tk);
        chk("core_key held during WAIT", core_key, old);
        drain();
        tick();
        chk("deferred key pulse in first idle cycle", vld_cyc, last_ov_cyc + 1);
        core_dly = 3;
        send_block(rnd128(), 1'b1, 1'b1, t);
        drain();

        // Last data beat and last key beat in the same cycle
        b = rnd128();
        nk = rnd128();
        for (int i = 0; i < NB; i++) begin
            EN = 1'b1;
            DIN = b[127-LW*i -: LW];
            K_EN = 1'b1;
            K_IN = nk[127-LW*i -: LW];
            t = cyc;
            tick();
        end
        EN = 1'b0;
        K_EN = 1'b0;
        key_q.push_back(nk);
        model_key = nk;
        blk_q.push_back(b);
        exp_q.push_back(cipher(nk, b));
        drain();
        chk("same-cycle key_vld at t+1", vld_cyc, t + 1);
        chk("same-cycle core_start at t+2", start_cyc, t + 2);

        // Reset after a partial block
        send_beats(rnd128(), 5, 1'b0, t);
        reset_n = 1'b0;
        #1;
        chk("mid reset OUT_VAL", OUT_VAL, 0);
        chk("mid reset BUSY", BUSY, 0);
        chk("mid reset core_din", core_din, 0);
        chk("mid reset core_key", core_key, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send_key(rnd128(), tk);
        send_block(rnd128(), 1'b1, 1'b1, t);
        drain();
        chk("post-reset start latency", start_cyc, t + 2);
`ifdef AES_STREAM_BLKCNT_EN
        chk("blk_cnt after one block", blk_cnt, 1);
`endif

        repeat (5) tick();
        chk("expected outputs left over", exp_q.size(), 0);
        chk("expected blocks left over", blk_q.size(), 0);
        chk("expected keys left over", key_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 SHALL have parameter LANE_W, default 1: serial lane width in bits; legal values 1, 2, 4, 8, 16, 32; N = 128/LANE_W beats per block.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port DIN, input, LANE_W: plaintext beat, MSB-first.
REQ-005 SHALL have port EN, input, 1: DIN beat valid.
REQ-006 SHALL have port K_IN, input, LANE_W: key beat, MSB-first.
REQ-007 SHALL have port K_EN, input, 1: K_IN beat valid.
REQ-008 SHALL have port DOUT, output, LANE_W: ciphertext beat, MSB-first.
REQ-009 SHALL have port OUT_VAL, output, 1: DOUT valid.
REQ-010 SHALL have port BUSY, output, 1: data beats not accepted.
REQ-011 SHALL have port core_key, output, 128: assembled cipher key to the AES core.
REQ-012 SHALL have port core_key_vld, output, 1: one-cycle pulse; core_key is new.
REQ-013 SHALL have port core_din, output, 128: assembled plaintext block.
REQ-014 SHALL have port core_start, output, 1: one-cycle start pulse.
REQ-015 SHALL have port core_done, input, 1: one-cycle pulse; core_dout is valid.
REQ-016 SHALL have port core_dout, input, 128: ciphertext from the core.

Function
REQ-017 SHALL shift K_IN into a 128-bit key shift register on each K_EN cycle, MSB-first, with a key beat counter 0..N-1 that wraps to 0 after the N-th beat.
REQ-018 SHALL complete a key on the N-th key beat; if the FSM is in IDLE, LOAD or HOLD, it SHALL copy the key to core_key and pulse core_key_vld in the next cycle; otherwise it SHALL hold the update pending and issue it in the first cycle back in IDLE.
REQ-019 SHALL keep key_ready set from the first core_key_vld pulse until reset; key_ready is never cleared by a new key load.
REQ-020 SHALL implement FSM states IDLE, LOAD, HOLD, START, WAIT and SHIFT.
REQ-021 IDLE/LOAD: each EN beat SHALL shift into the data register and increment the data counter; the first beat moves IDLE to LOAD; the N-th beat moves to HOLD and clears the counter.
REQ-022 HOLD: the FSM SHALL move to START when key_ready=1 and no key update is pending, and SHALL otherwise stay in HOLD.
REQ-023 START: core_din SHALL present the assembled block, core_start SHALL be 1 for exactly this cycle, and the next state SHALL be WAIT.
REQ-024 WAIT: on core_done=1, core_dout SHALL be captured into the output shift register and the next state SHALL be SHIFT; there is no timeout.
REQ-025 SHIFT: OUT_VAL SHALL be 1 for exactly N consecutive cycles, with DOUT = top LANE_W bits, shifting left each cycle; then the FSM SHALL return to IDLE.
REQ-026 BUSY SHALL be 1 in HOLD, START, WAIT and SHIFT; EN beats while BUSY=1 SHALL be dropped with no state change.
REQ-027 Latency: last data beat at cycle t with a key already loaded gives HOLD at t+1, core_start at t+2, and the first OUT_VAL in the cycle after core_done.
REQ-028 Last data beat and last key beat in the same cycle: core_key_vld SHALL pulse at t+1 and core_start SHALL pulse at t+2.
REQ-029 core_done outside WAIT SHALL be ignored.
REQ-030 DOUT SHALL be 0 whenever OUT_VAL=0.

Reset
REQ-031 reset_n=0 SHALL asynchronously force: state IDLE; all counters, shift registers, core_key and core_din to 0; key_ready, pending, BUSY, OUT_VAL, DOUT, core_key_vld and core_start to 0.
REQ-032 Reset mid-operation SHALL discard partial beats and any in-flight block; after release the first accepted beat is beat 0.

Configuration
REQ-033 With AES_STREAM_BLKCNT_EN defined, the block SHALL add output port blk_cnt[15:0], reset to 0 and incremented on each SHIFT-to-IDLE transition, wrapping 0xFFFF to 0; without the macro the port and counter SHALL not exist and the remaining behaviour SHALL be identical.

Verification
REQ-034 LANE_W=8: key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff, core model returns FIPS-197 result -> 16 OUT_VAL beats 69,c4,e0,d8,6a,7b,04,30,d8,cd,b7,80,70,b4,c5,5a.
REQ-035 LANE_W=1: plaintext sent before any key -> FSM stays in HOLD and core_start stays 0 until 128 key beats arrive; core_start then pulses 2 cycles after the last key beat.
REQ-036 EN held at 1 during WAIT/SHIFT with DIN=ff -> beats dropped; next block after IDLE is assembled exactly from post-IDLE beats.
REQ-037 New 128-beat key completes during WAIT -> core_key unchanged until return to IDLE, then one core_key_vld pulse with the new key.
REQ-038 reset_n pulsed low after 5 of 16 data beats (LANE_W=8) -> all outputs 0; a following full block encrypts correctly; with AES_STREAM_BLKCNT_EN, blk_cnt reads 1 after that block.
